// File: rtl/dram_model_pkg.sv
// Shared types and default timing for the cycle-level DRAM device model.
// The optional timing checker is enabled by defining DRAM_MODEL_TIMING_CHECK_EN.
package dram_model_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVATING,
        ROW_OPEN,
        PRECHARGING
    } dram_state_e;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ROW_W     = 11;
    localparam int DEF_COL_W     = 10;
    localparam int DEF_MEM_ROW_W = 4;
    localparam int DEF_T_RCD     = 4;
    localparam int DEF_T_RP      = 4;
    localparam int DEF_CAS_LAT   = 5;

    // Wide enough for any practical tRCD/tRP setting.
    localparam int CNT_W = 8;

    // A wait of N cycles is counted down from N-1 so that the state after the
    // final count is live exactly N edges after the command edge.
    function automatic logic [CNT_W-1:0] wait_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/dram_timing_model_if.sv
// DRAM command/data pin bundle between the wrapper (master) and the device model (slave).
interface dram_timing_model_if
    import dram_model_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROW_W  = DEF_ROW_W
);
    logic                  DRAM_CSn;
    logic                  DRAM_RASn;
    logic                  DRAM_CASn;
    logic [DATA_W/8-1:0]   DRAM_WEn;
    logic [ROW_W-1:0]      DRAM_A;
    logic [DATA_W-1:0]     DRAM_D;
    logic [DATA_W-1:0]     DRAM_Q;
    logic                  DRAM_valid;
    logic                  timing_err;

    modport master (
        output DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D,
        input  DRAM_Q, DRAM_valid, timing_err
    );

    modport slave (
        input  DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D,
        output DRAM_Q, DRAM_valid, timing_err
    );
endinterface

// File: rtl/dram_read_pipe.sv
// Fixed-latency read return pipe: DEPTH stages of {valid, data}, valid cleared by async reset.
module dram_read_pipe
    import dram_model_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_CAS_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);
    logic [DEPTH-1:0]  valid_sr;
    logic [DATA_W-1:0] data_sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_sr <= '0;
        end else begin
            valid_sr[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
            end
        end
    end

    // NOTE: storage (data stages here, the word array in the top) has no reset;
    // the matching valid bit is what qualifies it, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        data_sr[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
            data_sr[i] <= data_sr[i-1];
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_data  = data_sr[DEPTH-1];

endmodule

// File: rtl/dram_timing_model.sv
// Single-bank DRAM device model: row state machine, word array and CAS-latency read return.
// Defining DRAM_MODEL_TIMING_CHECK_EN enables the sticky timing_err protocol checker.
module dram_timing_model
    import dram_model_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ROW_W     = DEF_ROW_W,
    parameter int COL_W     = DEF_COL_W,
    parameter int MEM_ROW_W = DEF_MEM_ROW_W,
    parameter int T_RCD     = DEF_T_RCD,
    parameter int T_RP      = DEF_T_RP,
    parameter int CAS_LAT   = DEF_CAS_LAT
) (
    input logic                clk,
    input logic                rst,
    dram_timing_model_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = MEM_ROW_W + COL_W;
    localparam int WORDS = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    dram_state_e          state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [MEM_ROW_W-1:0] row, row_next;

    logic              cmd_ras;
    logic              cmd_cas;
    logic              cas_ok;
    logic              wr_en;
    logic              rd_en;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] mem [WORDS];
    logic [DATA_W-1:0] rd_word;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;
    logic              unused_addr;

    assign cmd_ras = !bus.DRAM_CSn && !bus.DRAM_RASn;
    // RAS has priority: with both strobes low the CAS half is dropped.
    assign cmd_cas = !bus.DRAM_CSn && !bus.DRAM_CASn && bus.DRAM_RASn;
    assign cas_ok  = cmd_cas && (state == ROW_OPEN);
    assign wr_en   = cas_ok && (bus.DRAM_WEn != '0);
    assign rd_en   = cas_ok && (bus.DRAM_WEn == '0);
    assign idx     = {row, bus.DRAM_A[COL_W-1:0]};

    // Upper row bits and the high address bits on CAS do not select storage.
    assign unused_addr = ^bus.DRAM_A;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            row   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            row   <= row_next;
        end
    end

    // NOTE: every output of this block is defaulted first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        row_next   = row;
        unique case (state)
            IDLE: begin
                if (cmd_ras) begin
                    row_next = bus.DRAM_A[MEM_ROW_W-1:0];
                    if (T_RCD > 1) begin
                        state_next = ACTIVATING;
                        cnt_next   = wait_load(T_RCD);
                    end else begin
                        state_next = ROW_OPEN;
                    end
                end
            end
            ACTIVATING: begin
                cnt_next = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_next = ROW_OPEN;
                end
            end
            ROW_OPEN: begin
                if (cmd_ras) begin
                    if (T_RP > 1) begin
                        state_next = PRECHARGING;
                        cnt_next   = wait_load(T_RP);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            PRECHARGING: begin
                cnt_next = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.DRAM_WEn[b]) begin
                    mem[idx][b*8 +: 8] <= bus.DRAM_D[b*8 +: 8];
                end
            end
        end
    end

    // A read CAS and a write CAS never share a cycle, so the array read needs no bypass.
    assign rd_word = mem[idx];

    dram_read_pipe #(
        .DATA_W (DATA_W),
        .DEPTH  (CAS_LAT)
    ) u_read_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_en),
        .in_data   (rd_word),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    assign bus.DRAM_valid = pipe_valid;
    assign bus.DRAM_Q     = pipe_valid ? pipe_data : '0;

`ifdef DRAM_MODEL_TIMING_CHECK_EN
    logic err_event;
    logic err;

    // CAS outside an open row, RAS+CAS together, or RAS before tRCD has elapsed.
    assign err_event = (!bus.DRAM_CSn && !bus.DRAM_CASn &&
                        (!bus.DRAM_RASn || (state != ROW_OPEN)))
                     || (cmd_ras && (state == ACTIVATING));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (err_event) begin
            err <= 1'b1;
        end
    end

    assign bus.timing_err = err;
`else
    assign bus.timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_dram_timing_model.sv
// Self-checking bench for dram_timing_model: directed scenarios then random commands vs a timestamp model.
module tb_dram_timing_model;
    import dram_model_pkg::*;

    localparam int DATA_W    = 32;
    localparam int ROW_W     = 11;
    localparam int COL_W     = 10;
    localparam int MEM_ROW_W = 4;
    localparam int T_RCD     = 4;
    localparam int T_RP      = 4;
    localparam int CAS_LAT   = 5;
    localparam int BYTES     = DATA_W / 8;

`ifdef DRAM_MODEL_TIMING_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dram_timing_model_if #(.DATA_W(DATA_W), .ROW_W(ROW_W)) dif ();

    dram_timing_model #(
        .DATA_W    (DATA_W),
        .ROW_W     (ROW_W),
        .COL_W     (COL_W),
        .MEM_ROW_W (MEM_ROW_W),
        .T_RCD     (T_RCD),
        .T_RP      (T_RP),
        .CAS_LAT   (CAS_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    logic [DATA_W-1:0] last_q;

    // Reference model: the bank is described by timestamps of the last
    // activate and precharge rather than by an explicit state machine.
    bit  row_active = 1'b0;
    int  act_t      = -1000;
    int  pre_t      = -1000;
    int  m_row      = 0;
    bit  m_err      = 1'b0;
    logic [DATA_W-1:0] m_data   [int];
    logic [BYTES-1:0]  m_known  [int];
    logic [DATA_W-1:0] exp_data [int];
    logic [BYTES-1:0]  exp_mask [int];
    bit                exp_due  [int];

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] byte_mask(input logic [BYTES-1:0] m);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (m[b]) r[b*8 +: 8] = 8'hFF;
        end
        return r;
    endfunction

    task automatic model_edge(input bit cs, input bit ras, input bit cas,
                              input logic [BYTES-1:0] wen, input logic [ROW_W-1:0] a,
                              input logic [DATA_W-1:0] d);
        bit opened;
        bit activating;
        int idx;
        logic [DATA_W-1:0] w;
        logic [BYTES-1:0]  k;
        opened     = row_active && (cycle >= act_t + T_RCD);
        activating = row_active && !opened;
        if (!cs) return;
        if (ras && cas) m_err = 1'b1;
        if (ras) begin
            if (activating) begin
                m_err = 1'b1;
            end else if (opened) begin
                row_active = 1'b0;
                pre_t      = cycle;
            end else if (cycle >= pre_t + T_RP) begin
                row_active = 1'b1;
                act_t      = cycle;
                m_row      = int'(a[MEM_ROW_W-1:0]);
            end
        end else if (cas) begin
            if (!opened) begin
                m_err = 1'b1;
            end else begin
                idx = m_row * (1 << COL_W) + int'(a[COL_W-1:0]);
                w   = m_data.exists(idx)  ? m_data[idx]  : '0;
                k   = m_known.exists(idx) ? m_known[idx] : '0;
                if (wen != '0) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (wen[b]) begin
                            w[b*8 +: 8] = d[b*8 +: 8];
                            k[b] = 1'b1;
                        end
                    end
                    m_data[idx]  = w;
                    m_known[idx] = k;
                end else begin
                    exp_due[cycle + CAS_LAT - 1]  = 1'b1;
                    exp_data[cycle + CAS_LAT - 1] = w;
                    exp_mask[cycle + CAS_LAT - 1] = k;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        bit due;
        logic [DATA_W-1:0] m;
        due = exp_due.exists(cycle);
        check({tag, "_valid"}, DATA_W'(dif.DRAM_valid), DATA_W'(due));
        if (dif.DRAM_valid === 1'b1) last_q = dif.DRAM_Q;
        if (due) begin
            if (exp_mask[cycle] != '0) begin
                m = byte_mask(exp_mask[cycle]);
                check({tag, "_q"}, dif.DRAM_Q & m, exp_data[cycle] & m);
            end
            exp_due.delete(cycle);
            exp_data.delete(cycle);
            exp_mask.delete(cycle);
        end else begin
            check({tag, "_q_idle"}, dif.DRAM_Q, '0);
        end
        check({tag, "_err"}, DATA_W'(dif.timing_err), DATA_W'(m_err && CHECK_EN));
    endtask

    // Entered at a negedge; drives pins, lets one posedge happen, checks at the next negedge.
    task automatic step(input string tag, input bit cs, input bit ras, input bit cas,
                        input logic [BYTES-1:0] wen, input logic [ROW_W-1:0] a,
                        input logic [DATA_W-1:0] d);
        dif.DRAM_CSn  = !cs;
        dif.DRAM_RASn = !ras;
        dif.DRAM_CASn = !cas;
        dif.DRAM_WEn  = wen;
        dif.DRAM_A    = a;
        dif.DRAM_D    = d;
        @(posedge clk);
        model_edge(cs, ras, cas, wen, a, d);
        @(negedge clk);
        check_outputs(tag);
        cycle++;
    endtask

    // Chip deselected with random garbage on every other pin.
    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 BYTES'($urandom), ROW_W'($urandom), $urandom);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_valid"}, DATA_W'(dif.DRAM_valid), '0);
        check({tag, "_q"}, dif.DRAM_Q, '0);
        check({tag, "_err"}, DATA_W'(dif.timing_err), '0);
        exp_due.delete();
        exp_data.delete();
        exp_mask.delete();
        row_active = 1'b0;
        pre_t      = -1000;
        m_err      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle++;
    endtask

    task automatic random_step();
        bit cs, ras, cas;
        int k;
        logic [ROW_W-1:0]  a;
        logic [BYTES-1:0]  wen;
        cs  = ($urandom_range(0, 99) >= 8);
        k   = $urandom_range(0, 99);
        ras = (k < 15);
        cas = (k >= 12) && (k < 70);
        if (ras) begin
            a = ROW_W'($urandom);
        end else begin
            a = '0;
            a[2:0] = 3'($urandom);
            a[ROW_W-1] = 1'($urandom);
        end
        wen = ($urandom_range(0, 1) == 1) ? BYTES'($urandom) : '0;
        step("rand", cs, ras, cas, wen, a, $urandom);
    endtask

    initial begin
        rst = 1'b1;
        dif.DRAM_CSn  = 1'b1;
        dif.DRAM_RASn = 1'b1;
        dif.DRAM_CASn = 1'b1;
        dif.DRAM_WEn  = '0;
        dif.DRAM_A    = '0;
        dif.DRAM_D    = '0;
        @(negedge clk);
        do_reset("reset");

        // 1: activate row 3, write col 5 after tRCD, read it back after CAS latency.
        last_q = '0;
        step("t1_act", 1, 1, 0, '0, 11'd3, '0);
        idle("t1_rcd", 3);
        step("t1_wr", 1, 0, 1, 4'hF, 11'd5, 32'hDEADBEEF);
        step("t1_rd", 1, 0, 1, 4'h0, 11'd5, '0);
        idle("t1_lat", 6);
        check("t1_q_literal", last_q, 32'hDEADBEEF);

        // 2: byte-lane write merges into an existing word.
        last_q = '0;
        step("t2_wr", 1, 0, 1, 4'hF, 11'd6, 32'h11223344);
        step("t2_bw", 1, 0, 1, 4'b0010, 11'd6, 32'h0000AA00);
        step("t2_rd", 1, 0, 1, 4'h0, 11'd6, '0);
        idle("t2_lat", 6);
        check("t2_q_literal", last_q, 32'h1122AA44);

        // 3: four back-to-back reads return four back-to-back valid pulses in order.
        last_q = '0;
        for (int i = 0; i < 4; i++) step("t3_wr", 1, 0, 1, 4'hF, ROW_W'(i), 32'hC0DE0000 + i);
        for (int i = 0; i < 4; i++) step("t3_rd", 1, 0, 1, 4'h0, ROW_W'(i), '0);
        idle("t3_lat", 6);
        check("t3_q_last", last_q, 32'hC0DE0003);

        // 4: precharge, activate row 4 (upper row bits set, ignored), col 5 is a different word.
        last_q = '0;
        step("t4_pre", 1, 1, 0, '0, '0, '0);
        idle("t4_rp", 3);
        step("t4_act", 1, 1, 0, '0, 11'h404, '0);
        idle("t4_rcd", 3);
        step("t4_wr", 1, 0, 1, 4'hF, 11'h405, 32'h0BADF00D);
        step("t4_rd", 1, 0, 1, 4'h0, 11'd5, '0);
        idle("t4_lat", 6);
        check("t4_q_literal", last_q, 32'h0BADF00D);

        // 5: CAS two cycles after activate is dropped and flagged.
        last_q = '0;
        step("t5_pre", 1, 1, 0, '0, '0, '0);
        idle("t5_rp", 3);
        step("t5_act", 1, 1, 0, '0, 11'd3, '0);
        idle("t5_gap", 1);
        step("t5_early", 1, 0, 1, 4'hF, 11'd5, 32'h00000000);
        idle("t5_gap", 1);
        step("t5_rd", 1, 0, 1, 4'h0, 11'd5, '0);
        idle("t5_lat", 6);
        check("t5_q_literal", last_q, 32'hDEADBEEF);
        check("t5_err_sticky", DATA_W'(dif.timing_err), DATA_W'(CHECK_EN));

        // 6: reset while a read is in flight; the read and a CAS right after reset vanish.
        last_q = '0;
        step("t6_rd", 1, 0, 1, 4'h0, 11'd5, '0);
        idle("t6_pend", 2);
        do_reset("t6_rst");
        step("t6_cas", 1, 0, 1, 4'h0, 11'd5, '0);
        idle("t6_quiet", 8);
        check("t6_no_valid", last_q, '0);

        // Random command stream with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset("rand_rst");
            else random_step();
        end
        idle("drain", 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
